// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing, EX forwarding selects and MEM-wait FSM with time-out.
// Optional performance counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q;
  logic       freeze, lw_stall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_q | (state_d == ERR);
    end
  end
  // Completion beats time-out: MemReadyM is tested before the counter limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (MemReqM && !MemReadyM) begin
        state_d = MEM_WAIT;
        cnt_d   = 8'd1;
      end
    end else if (state_q == MEM_WAIT) begin
      if (MemReadyM) begin
        state_d = RUN;
        cnt_d   = '0;
      end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
        state_d = ERR;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end
  always_comb begin
    freeze = ((state_q == RUN) && MemReqM && !MemReadyM) ||
             ((state_q == MEM_WAIT) && !MemReadyM) || (state_q == ERR);
    lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    StallF = freeze || lw_stall;
    StallD = freeze || lw_stall;
    StallE = freeze;
    StallM = freeze;
    FlushW = freeze;
    FlushD = !freeze && PCSrcE;
    FlushE = !freeze && (lw_stall || PCSrcE);
    ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  assign mem_err = mem_err_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(StallF);
      flush_cnt_q <= flush_cnt_q + CNT_W'(FlushE);
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven combinational checks plus hand-written MEM-wait/time-out sequences.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int errors = 0;
  int checks = 0;
  localparam logic [10:0] FRZ = 11'b1111_001_00_00;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lsrc, pcsrc, rwm, rww;
    logic [10:0] exp;
  } vec_t;
  vec_t tv[13];

  function automatic logic [10:0] outs();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          name         rs1d rs2d rs1e rs2e rde rdm rdw lsrc pc rwm rww  exp
    tv[0]  = '{"idle",       0,   0,   0,   0,   0,  0,  0,  0,   0, 0,  0,  11'b0000_000_00_00};
    tv[1]  = '{"lw_rs1",     5,   0,   0,   0,   5,  0,  0,  1,   0, 0,  0,  11'b1100_010_00_00};
    tv[2]  = '{"lw_rs2",     1,   5,   0,   0,   5,  0,  0,  1,   0, 0,  0,  11'b1100_010_00_00};
    tv[3]  = '{"lw_x0",      0,   0,   0,   0,   0,  0,  0,  1,   0, 0,  0,  11'b0000_000_00_00};
    tv[4]  = '{"nolw",       5,   5,   0,   0,   5,  0,  0,  0,   0, 0,  0,  11'b0000_000_00_00};
    tv[5]  = '{"fwdA_mem",   0,   0,   7,   0,   0,  7,  7,  0,   0, 1,  1,  11'b0000_000_10_00};
    tv[6]  = '{"fwdA_wb",    0,   0,   7,   0,   0,  7,  7,  0,   0, 0,  1,  11'b0000_000_01_00};
    tv[7]  = '{"fwdA_x0",    0,   0,   0,   0,   0,  0,  0,  0,   0, 1,  1,  11'b0000_000_00_00};
    tv[8]  = '{"fwdB_wb",    0,   0,   0,   9,   0,  9,  9,  0,   0, 0,  1,  11'b0000_000_00_01};
    tv[9]  = '{"fwdB_mem",   0,   0,   0,   9,   0,  9,  2,  0,   0, 1,  1,  11'b0000_000_00_10};
    tv[10] = '{"branch",     0,   0,   0,   0,   0,  0,  0,  0,   1, 0,  0,  11'b0000_110_00_00};
    tv[11] = '{"br_and_lw",  3,   0,   0,   0,   3,  0,  0,  1,   1, 0,  0,  11'b1100_110_00_00};
    tv[12] = '{"fwdAB_mem",  0,   0,   3,   3,   0,  3,  4,  0,   0, 1,  1,  11'b0000_000_10_10};
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_err", 32'(mem_err), 32'h0);
    for (int i = 0; i < 13; i++) begin
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
        {tv[i].rs1d, tv[i].rs2d, tv[i].rs1e, tv[i].rs2e, tv[i].rde, tv[i].rdm, tv[i].rdw};
      {ResultSrcE0, PCSrcE, RegWriteM, RegWriteW} = {tv[i].lsrc, tv[i].pcsrc, tv[i].rwm, tv[i].rww};
      #1;
      chk(tv[i].name, 32'(outs()), 32'(tv[i].exp));
    end
    clr();
    // 3-cycle memory wait; a branch raised during the freeze must wait for it to drop
    tick();
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) PCSrcE = 1'b1;
      #1;
      chk("mem_wait", 32'(outs()), 32'(FRZ));
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    chk("mem_done_branch", 32'(outs()), 32'(11'b0000_110_00_00));
    tick();
    clr();
    #1;
    chk("after_wait", 32'(outs()), 32'h0);
    // ready in the first MEM cycle: no stall, and no lingering wait state
    MemReqM = 1'b1;
    MemReadyM = 1'b1;
    #1;
    chk("fast_mem", 32'(outs()), 32'h0);
    tick();
    clr();
    #1;
    chk("fast_mem_next", 32'(outs()), 32'h0);
    // ready arrives exactly when the counter reaches the limit: completion wins
    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("limit_wait", 32'(outs()), 32'(FRZ));
      tick();
    end
    MemReadyM = 1'b1;
    #1;
    chk("limit_ready", 32'(outs()), 32'h0);
    tick();
    clr();
    #1;
    chk("limit_no_err", 32'(mem_err), 32'h0);
    chk("limit_run", 32'(outs()), 32'h0);
    // time-out: five frozen cycles (RUN + counter 1..4), then ERR
    MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_wait", 32'(outs()), 32'(FRZ));
      chk("to_err_low", 32'(mem_err), 32'h0);
      tick();
    end
    chk("to_err_set", 32'(mem_err), 32'h1);
    MemReqM = 1'b0;
    MemReadyM = 1'b1;
    ResultSrcE0 = 1'b1;
    RdE = 5'd5;
    Rs1D = 5'd5;
    PCSrcE = 1'b1;
    #1;
    chk("err_hold", 32'(outs()), 32'(FRZ));
    tick();
    chk("err_sticky", 32'(mem_err), 32'h1);
    chk("err_hold2", 32'(outs()), 32'(FRZ));
    clr();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'h0);
    chk("async_rst_err", 32'(mem_err), 32'h0);
    #1 reset = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    tick();
    MemReqM = 1'b1;
    repeat (3) tick();
    MemReadyM = 1'b1;
    tick();
    clr();
    ResultSrcE0 = 1'b1;
    RdE = 5'd5;
    Rs1D = 5'd5;
    tick();
    clr();
    #1;
    chk("stall_cnt", stall_cnt, 32'd4);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
